// File: rtl/avalon_mem_arbiter.sv
// Two-master, one-slave Avalon-MM round-robin arbiter sharing one word-addressed memory
// between the CPU instruction port (m0) and the data port (m1); read data returns to its issuer.
module avalon_mem_arbiter #(
    parameter int unsigned STALL_LIMIT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteenable,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [3:0]  s_byteenable,
    output logic [31:0] s_writedata,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        protocol_err,
    output logic        timeout_err
);

    localparam int unsigned CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);
    localparam logic LIMIT_EN = (STALL_LIMIT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_owner_q, rd_owner_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            stalled_q, stalled_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wd_q, wd_d;
    logic            protocol_err_q, protocol_err_d;
    logic            timeout_err_q, timeout_err_d;

    logic            granted_s;
    logic            gnt_m1_s;
    logic            sel_read_s;
    logic            sel_write_s;
    logic [31:0]     sel_addr_s;
    logic [3:0]      sel_be_s;
    logic [31:0]     sel_wd_s;
    logic            req0_s;
    logic            req1_s;
    logic            sel_req_s;
    logic            accept_s;
    logic            stall_s;
    logic            changed_s;
    logic            both_s;
    logic            drop_s;

    // Select the granted master's bus; IDLE forwards nothing.
    always_comb begin
        granted_s   = 1'b0;
        gnt_m1_s    = 1'b0;
        sel_read_s  = 1'b0;
        sel_write_s = 1'b0;
        sel_addr_s  = 32'h0;
        sel_be_s    = 4'h0;
        sel_wd_s    = 32'h0;
        case (state_q)
            GNT0: begin
                granted_s   = 1'b1;
                sel_read_s  = m0_read;
                sel_write_s = m0_write;
                sel_addr_s  = m0_addr;
                sel_be_s    = m0_byteenable;
                sel_wd_s    = m0_writedata;
            end
            GNT1: begin
                granted_s   = 1'b1;
                gnt_m1_s    = 1'b1;
                sel_read_s  = m1_read;
                sel_write_s = m1_write;
                sel_addr_s  = m1_addr;
                sel_be_s    = m1_byteenable;
                sel_wd_s    = m1_writedata;
            end
            default: begin
                granted_s = 1'b0;
            end
        endcase
    end

    assign s_read         = sel_read_s;
    assign s_write        = sel_write_s & ~sel_read_s;
    assign s_addr         = sel_addr_s;
    assign s_byteenable   = sel_be_s;
    assign s_writedata    = sel_wd_s;
    assign m0_waitrequest = (state_q == GNT0) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (state_q == GNT1) ? s_waitrequest : 1'b1;
    assign m0_readdata    = (rd_valid_q & ~rd_owner_q) ? s_readdata : 32'h0;
    assign m1_readdata    = (rd_valid_q &  rd_owner_q) ? s_readdata : 32'h0;
    assign protocol_err   = protocol_err_q;
    assign timeout_err    = timeout_err_q;

    assign req0_s    = m0_read | m0_write;
    assign req1_s    = m1_read | m1_write;
    assign sel_req_s = sel_read_s | sel_write_s;
    assign accept_s  = granted_s & sel_req_s & ~s_waitrequest;
    assign stall_s   = granted_s & sel_req_s & s_waitrequest;
    assign drop_s    = granted_s & ~sel_req_s;
    assign both_s    = (m0_read & m0_write) | (m1_read & m1_write);
    assign changed_s = stalled_q & granted_s & sel_req_s &
                       ((sel_addr_s != addr_q) | (sel_be_s != be_q) | (sel_wd_s != wd_q));

    // Arbitration, read-return routing, stall timing and error tracking.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0_s & req1_s) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req0_s) begin
                    state_d = GNT0;
                end else if (req1_s) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!req0_s) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    last_d  = 1'b0;
                    state_d = req1_s ? GNT1 : IDLE;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (!req1_s) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    last_d  = 1'b1;
                    state_d = req0_s ? GNT0 : IDLE;
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_valid_d = accept_s & sel_read_s;
        if (accept_s & sel_read_s) begin
            rd_owner_d = gnt_m1_s;
        end else begin
            rd_owner_d = rd_owner_q;
        end

        // Counter saturates at the limit so a long stall never wraps back below it.
        if (state_d != state_q) begin
            stall_cnt_d = {CW{1'b0}};
        end else if (stall_s && (stall_cnt_q != LIMIT)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        stalled_d      = stall_s;
        addr_d         = sel_addr_s;
        be_d           = sel_be_s;
        wd_d           = sel_wd_s;
        protocol_err_d = protocol_err_q | changed_s | both_s | drop_s;
        timeout_err_d  = timeout_err_q | (LIMIT_EN & stall_s & (stall_cnt_d == LIMIT));
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_owner_q     <= 1'b0;
            stall_cnt_q    <= {CW{1'b0}};
            stalled_q      <= 1'b0;
            addr_q         <= 32'h0;
            be_q           <= 4'h0;
            wd_q           <= 32'h0;
            protocol_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            rd_valid_q     <= rd_valid_d;
            rd_owner_q     <= rd_owner_d;
            stall_cnt_q    <= stall_cnt_d;
            stalled_q      <= stalled_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wd_q           <= wd_d;
            protocol_err_q <= protocol_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: cycle table for arbitration plus hand sequences, with a
// read-data scoreboard fed from a reference copy of the memory.
module tb_avalon_mem_arbiter;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_writedata, m1_addr, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_addr, s_writedata;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata = 32'h0;
    logic        protocol_err, timeout_err;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.STALL_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .protocol_err(protocol_err), .timeout_err(timeout_err)
    );

    typedef struct {
        logic r0, w0, r1, w1, sw;
        logic e_w0, e_w1, e_sr, e_sw;
    } vec_t;
    typedef struct {
        logic        m1;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs[10];
    exp_t        exp_q[$];
    logic [31:0] mem[16];
    logic [31:0] ref_mem[16];
    logic        mem_init = 1'b0;
    logic        ref_init = 1'b0;
    logic        mon_en = 1'b0;
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h12345678;
            1:       return 32'h0BADF00D;
            default: return 32'hA5A50000 | 32'(i);
        endcase
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic r1, input logic w1,
                          input logic sw);
        m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1; s_waitrequest = sw;
    endtask

    // Slave memory: 1-cycle registered readdata, byte-enabled writes.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (s_write && !s_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (s_byteenable[b]) mem[s_addr[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
            end
            if (s_read && !s_waitrequest) s_readdata <= mem[s_addr[5:2]];
        end
    end

    // Scoreboard: push on a master-side accepted read, check routing one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (!ref_init) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end else if (!mon_en) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.m1) begin
                    chk32("m1_readdata", m1_readdata, e.data);
                    chk32("m0_readdata_quiet", m0_readdata, 32'h0);
                end else begin
                    chk32("m0_readdata", m0_readdata, e.data);
                    chk32("m1_readdata_quiet", m1_readdata, 32'h0);
                end
            end else begin
                chk32("m0_readdata_idle", m0_readdata, 32'h0);
                chk32("m1_readdata_idle", m1_readdata, 32'h0);
            end
            if (m0_read && !m0_waitrequest) begin
                e.m1 = 1'b0; e.data = ref_mem[m0_addr[5:2]]; exp_q.push_back(e);
            end else if (m0_write && !m0_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (m0_byteenable[b]) ref_mem[m0_addr[5:2]][8*b +: 8] = m0_writedata[8*b +: 8];
            end
            if (m1_read && !m1_waitrequest) begin
                e.m1 = 1'b1; e.data = ref_mem[m1_addr[5:2]]; exp_q.push_back(e);
            end else if (m1_write && !m1_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (m1_byteenable[b]) ref_mem[m1_addr[5:2]][8*b +: 8] = m1_writedata[8*b +: 8];
            end
        end
    end

    task automatic apply_reset;
        mon_en = 1'b0;
        reset  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m0_read = 1'($urandom); m0_write = 1'($urandom);
            m1_read = 1'($urandom); m1_write = 1'($urandom);
            s_waitrequest = 1'($urandom);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            mid;
            chk1("rst_s_read", s_read, 1'b0);
            chk1("rst_s_write", s_write, 1'b0);
            chk32("rst_s_addr", s_addr, 32'h0);
            chk1("rst_m0_wait", m0_waitrequest, 1'b1);
            chk1("rst_m1_wait", m1_waitrequest, 1'b1);
            chk32("rst_m0_rdata", m0_readdata, 32'h0);
            chk32("rst_m1_rdata", m1_readdata, 32'h0);
            chk1("rst_protocol_err", protocol_err, 1'b0);
            chk1("rst_timeout_err", timeout_err, 1'b0);
            tick;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m0_addr = 32'hBFC00000; m1_addr = 32'hBFC00004;
        m0_writedata = 32'h0; m1_writedata = 32'hCAFEF00D;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_writedata = 32'h0; m1_writedata = 32'h0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        tick;
        tick;
        apply_reset;

        //                r0    w0    r1    w1    sw    e_w0  e_w1  e_sr  e_sw
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1, vecs[i].sw);
            mid;
            chk1($sformatf("v%0d_m0_wait", i), m0_waitrequest, vecs[i].e_w0);
            chk1($sformatf("v%0d_m1_wait", i), m1_waitrequest, vecs[i].e_w1);
            chk1($sformatf("v%0d_s_read", i), s_read, vecs[i].e_sr);
            chk1($sformatf("v%0d_s_write", i), s_write, vecs[i].e_sw);
            tick;
        end

        // Single read by m0
        m0_addr = 32'hBFC00000;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mid; chk1("t2_idle_wait", m0_waitrequest, 1'b1);
        tick;
        mid; chk1("t2_gnt_wait", m0_waitrequest, 1'b0);
        chk1("t2_s_read", s_read, 1'b1);
        chk32("t2_s_addr", s_addr, 32'hBFC00000);
        chk1("t2_m1_wait", m1_waitrequest, 1'b1);
        tick; m0_read = 1'b0;
        mid; chk32("t2_m0_rdata", m0_readdata, 32'h12345678);
        chk32("t2_m1_rdata", m1_readdata, 32'h0);
        chk1("t2_back_idle", m0_waitrequest, 1'b1);
        tick;

        // Write handoff: m1 writes, m0 reads the same word right after
        m0_addr = 32'hBFC00010; m1_addr = 32'hBFC00010; m1_writedata = 32'hAABBCCDD;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        mid; chk1("t4_idle_m1_wait", m1_waitrequest, 1'b1);
        tick;
        mid; chk1("t4_m1_wait", m1_waitrequest, 1'b0);
        chk1("t4_s_write", s_write, 1'b1);
        chk32("t4_s_wdata", s_writedata, 32'hAABBCCDD);
        chk1("t4_m0_held", m0_waitrequest, 1'b1);
        tick; m1_write = 1'b0;
        mid; chk1("t4_m0_gnt", m0_waitrequest, 1'b0);
        chk32("t4_s_addr", s_addr, 32'hBFC00010);
        tick; m0_read = 1'b0;
        mid; chk32("t4_m0_rdata", m0_readdata, 32'hAABBCCDD);
        tick;

        // Slave stall past the limit
        m0_addr = 32'hBFC00000;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mid; tick;
        mid; chk1("t5_first_stall_wait", m0_waitrequest, 1'b1);
        chk1("t5_first_timeout", timeout_err, 1'b0);
        for (int i = 1; i <= LIM + 1; i++) begin
            tick;
            mid;
            chk1($sformatf("t5_timeout_%0d", i), timeout_err, (i >= LIM));
            chk1($sformatf("t5_held_%0d", i), s_read, 1'b1);
        end
        tick; s_waitrequest = 1'b0;
        mid; chk1("t5_release_wait", m0_waitrequest, 1'b0);
        tick; m0_read = 1'b0;
        mid; chk32("t5_m0_rdata", m0_readdata, 32'h12345678);
        chk1("t5_timeout_sticky", timeout_err, 1'b1);
        chk1("t5_no_protocol_err", protocol_err, 1'b0);
        tick;

        // Granted master abandons its read mid-stall
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mid; tick;
        mid; chk1("t6a_stall", s_read, 1'b1);
        tick;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mid; chk1("t6a_no_s_read", s_read, 1'b0);
        chk1("t6a_no_s_write", s_write, 1'b0);
        chk1("t6a_flag_pre", protocol_err, 1'b0);
        tick;
        mid; chk1("t6a_flag", protocol_err, 1'b1);
        chk1("t6a_idle_wait", m0_waitrequest, 1'b1);
        chk1("t6a_idle_s_read", s_read, 1'b0);
        tick;
        apply_reset;

        // Read and write together from m1
        m1_writedata = 32'h55555555;
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        mid; tick;
        mid; chk1("t6b_s_read", s_read, 1'b1);
        chk1("t6b_s_write", s_write, 1'b0);
        chk1("t6b_m1_wait", m1_waitrequest, 1'b0);
        tick; m1_read = 1'b0; m1_write = 1'b0;
        mid; chk1("t6b_flag", protocol_err, 1'b1);
        tick;
        apply_reset;

        // Address changes while stalled
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mid; tick;
        mid; tick;
        m0_addr = 32'hBFC00008;
        mid; chk32("t6c_s_addr_fwd", s_addr, 32'hBFC00008);
        chk1("t6c_flag_pre", protocol_err, 1'b0);
        tick; s_waitrequest = 1'b0;
        mid; chk1("t6c_flag", protocol_err, 1'b1);
        tick; m0_read = 1'b0;
        mid; tick;
        mid; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
